// File: rtl/mem_access.sv
// mem_access -- memory stage of the pipeline.
//
// Takes the decoded memory controls (memr/memw/memt/wreg/wback) plus the
// execute-stage result. Loads and stores go out on a request/grant/read-valid
// bus, with byte-lane steering on the way out and sign/zero extension on the
// way back. Upstream is stalled while a transaction is outstanding.
// Non-memory operations pass through as a one-cycle pipeline register.
//
// Access kind encoding (i_memt):
//   0 LoadByte   1 LoadHalf   2 LoadWord   3 ULoadByte   4 ULoadHalf
//   5 StoreByte  6 StoreHalf  7 StoreWord
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid           upstream operation valid
//   i_memr / i_memw   operation is a load / a store
//   i_memt            access kind (see the table above)
//   i_addr            effective address, or ALU result for non-memory ops
//   i_wdata           store data
//   i_wreg, i_wback   destination register and writeback enable
//   o_stall           upstream must hold its inputs this cycle
//   o_valid           result valid toward writeback
//   o_data            load data or pass-through ALU result
//   o_wreg, o_wback   destination register, writeback enable (0 on error)
//   o_err             misaligned, illegal or timed-out access
//   bus_req           request, held until bus_gnt
//   bus_we            1 = write
//   bus_addr          word-aligned address
//   bus_wstrb         byte write strobes
//   bus_wdata         lane-replicated store data
//   bus_gnt           bus accepted the request this cycle
//   bus_rvalid        read data valid (ignored outside WAIT)
//   bus_rdata         read data
//
// Bus handshake: bus_req and all bus_* payload signals stay stable from the
// first REQ cycle up to and including the cycle in which bus_gnt is high;
// bus_req drops the cycle after. For loads, exactly one bus_rvalid is taken
// while in WAIT; any bus_rvalid seen in another state is dropped.

module mem_access #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_memr,
    input  logic        i_memw,
    input  logic [2:0]  i_memt,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_wreg,
    input  logic        i_wback,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [4:0]  o_wreg,
    output logic        o_wback,
    output logic        o_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] MT_LB  = 3'd0;
    localparam logic [2:0] MT_LH  = 3'd1;
    localparam logic [2:0] MT_LW  = 3'd2;
    localparam logic [2:0] MT_ULB = 3'd3;
    localparam logic [2:0] MT_ULH = 3'd4;
    localparam logic [2:0] MT_SB  = 3'd5;
    localparam logic [2:0] MT_SH  = 3'd6;
    localparam logic [2:0] MT_SW  = 3'd7;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    memt_q;
    logic          we_q;
    logic [4:0]    wreg_q;
    logic          wback_q;
    logic          err_q;
    logic [31:0]   data_q;
    logic          pt_valid;

    logic          pass_op;
    logic          mem_op;
    logic          legal;
    logic          aligned;
    logic          expired;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_data;

    // ---------------------------------------------------------------
    // Decode of the incoming operation (only meaningful in IDLE)
    // ---------------------------------------------------------------
    always_comb begin
        pass_op = i_valid && !i_memr && !i_memw;
        mem_op  = i_valid && (i_memr || i_memw);
        // Exactly one direction, and the kind must belong to that direction:
        // kinds 0..4 are loads, 5..7 are stores.
        legal   = (i_memr ^ i_memw) && (i_memr ? (i_memt <= MT_ULH) : (i_memt >= MT_SB));
        case (i_memt)
            MT_LH, MT_ULH, MT_SH: aligned = (i_addr[0] == 1'b0);
            MT_LW, MT_SW:         aligned = (i_addr[1:0] == 2'b00);
            default:              aligned = 1'b1;
        endcase
    end

    assign expired = (cnt == CNT_LAST);

    // ---------------------------------------------------------------
    // FSM: state register and next-state logic
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_n = (legal && aligned) ? REQ : RESP;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_n = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid || expired) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Load lane extraction from the live bus data
    // ---------------------------------------------------------------
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (memt_q)
            MT_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            MT_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            MT_ULB:  load_data = {24'd0, ld_byte};
            MT_ULH:  load_data = {16'd0, ld_half};
            default: load_data = bus_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            memt_q   <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wback_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            pt_valid <= 1'b0;
        end else begin
            pt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pass_op) begin
                        pt_valid <= 1'b1;
                        data_q   <= i_addr;
                        wreg_q   <= i_wreg;
                        wback_q  <= i_wback;
                        err_q    <= 1'b0;
                    end else if (mem_op) begin
                        addr_q   <= i_addr;
                        wdata_q  <= i_wdata;
                        memt_q   <= i_memt;
                        we_q     <= i_memw;
                        wreg_q   <= i_wreg;
                        // Stores never write a register back.
                        wback_q  <= i_wback && !i_memw;
                        err_q    <= !(legal && aligned);
                        data_q   <= '0;
                    end
                end
                REQ: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Data arriving on the expiry cycle still counts as success.
                    if (bus_rvalid) begin
                        data_q <= load_data;
                    end else if (expired) begin
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately
    // ---------------------------------------------------------------
    always_comb begin
        o_stall   = (state != IDLE) || mem_op;
        o_valid   = pt_valid || (state == RESP);
        o_data    = data_q;
        o_wreg    = wreg_q;
        o_wback   = o_valid && wback_q && !err_q;
        o_err     = (state == RESP) && err_q;

        bus_req   = (state == REQ);
        bus_we    = bus_req && we_q;
        bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_wstrb = 4'b0000;
        bus_wdata = 32'd0;
        if (bus_we) begin
            case (memt_q)
                MT_SB: begin
                    bus_wstrb = 4'b0001 << addr_q[1:0];
                    bus_wdata = {4{wdata_q[7:0]}};
                end
                MT_SH: begin
                    bus_wstrb = 4'b0011 << addr_q[1:0];
                    bus_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    bus_wstrb = 4'b1111;
                    bus_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed bench for mem_access.
//
// Inputs change 2 ns after a rising edge; outputs are checked 1 ns later,
// well clear of the next rising edge.

module tb_mem_access;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_memr;
    logic        i_memw;
    logic [2:0]  i_memt;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_wreg;
    logic        i_wback;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_data;
    logic [4:0]  o_wreg;
    logic        o_wback;
    logic        o_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_memr     (i_memr),
        .i_memw     (i_memw),
        .i_memt     (i_memt),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_wreg     (i_wreg),
        .i_wback    (i_wback),
        .o_stall    (o_stall),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_wreg     (o_wreg),
        .o_wback    (o_wback),
        .o_err      (o_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] wr, input logic wb);
        i_valid = 1'b1;
        i_memr  = r;
        i_memw  = w;
        i_memt  = t;
        i_addr  = a;
        i_wdata = wd;
        i_wreg  = wr;
        i_wback = wb;
        #1;
    endtask

    task automatic drop_inputs();
        i_valid = 1'b0;
        i_memr  = 1'b0;
        i_memw  = 1'b0;
        i_memt  = 3'd0;
        i_addr  = 32'd0;
        i_wdata = 32'd0;
        i_wreg  = 5'd0;
        i_wback = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n      = 1'b1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        drop_inputs();
        #1 rst_n = 1'b0;
        #2;
        chk1 ("rst_valid", o_valid, 1'b0);
        chk1 ("rst_stall", o_stall, 1'b0);
        chk1 ("rst_req",   bus_req, 1'b0);
        chk32("rst_data",  o_data,  32'd0);
        chk1 ("rst_err",   o_err,   1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---- pass-through ----
        issue(1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1);
        chk1("pt_stall_accept", o_stall, 1'b0);
        cyc();
        drop_inputs();
        #1;
        chk1 ("pt_valid", o_valid, 1'b1);
        chk32("pt_data",  o_data,  32'h1234);
        chk32("pt_wreg",  {27'd0, o_wreg}, 32'd5);
        chk1 ("pt_wback", o_wback, 1'b1);
        chk1 ("pt_stall", o_stall, 1'b0);
        cyc();
        #1;
        chk1("pt_valid_drop", o_valid, 1'b0);

        // ---- LoadByte signed at 0x103, rvalid two cycles after grant ----
        issue(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 5'd7, 1'b1);
        chk1("lb_stall_accept", o_stall, 1'b1);
        chk1("lb_req_accept",   bus_req, 1'b0);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        #1;
        chk1 ("lb_req",   bus_req,  1'b1);
        chk1 ("lb_we",    bus_we,   1'b0);
        chk32("lb_addr",  bus_addr, 32'h100);
        chk1 ("lb_stall_req", o_stall, 1'b1);
        cyc();
        bus_gnt = 1'b0;
        #1;
        chk1("lb_req_drop",    bus_req, 1'b0);
        chk1("lb_stall_wait",  o_stall, 1'b1);
        chk1("lb_valid_wait",  o_valid, 1'b0);
        cyc();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h80112233;
        #1;
        chk1("lb_stall_wait2", o_stall, 1'b1);
        cyc();
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        #1;
        chk1 ("lb_valid", o_valid, 1'b1);
        chk32("lb_data",  o_data,  32'hFFFFFF80);
        chk1 ("lb_wback", o_wback, 1'b1);
        chk32("lb_wreg",  {27'd0, o_wreg}, 32'd7);
        chk1 ("lb_err",   o_err,   1'b0);
        chk1 ("lb_stall_resp", o_stall, 1'b1);
        cyc();
        #1;
        chk1("lb_valid_drop", o_valid, 1'b0);
        chk1("lb_stall_drop", o_stall, 1'b0);

        // ---- ULoadHalf at 0x102, same bus data ----
        issue(1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 5'd3, 1'b1);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        cyc();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h80112233;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        chk1 ("ulh_valid", o_valid, 1'b1);
        chk32("ulh_data",  o_data,  32'h00008011);
        cyc();

        // ---- StoreHalf at 0x22, grant delayed 3 cycles ----
        issue(1'b0, 1'b1, 3'd6, 32'h22, 32'hDEADBEEF, 5'd0, 1'b0);
        cyc();
        drop_inputs();
        for (int i = 0; i < 4; i++) begin
            bus_gnt = (i == 3);
            #1;
            chk1 ("sh_req",   bus_req,  1'b1);
            chk1 ("sh_we",    bus_we,   1'b1);
            chk32("sh_addr",  bus_addr, 32'h20);
            chk32("sh_wstrb", {28'd0, bus_wstrb}, 32'hC);
            chk32("sh_wdata", bus_wdata, 32'hBEEFBEEF);
            chk1 ("sh_valid_req", o_valid, 1'b0);
            cyc();
        end
        bus_gnt = 1'b0;
        #1;
        chk1("sh_req_drop", bus_req, 1'b0);
        chk1("sh_valid",    o_valid, 1'b1);
        chk1("sh_wback",    o_wback, 1'b0);
        chk1("sh_err",      o_err,   1'b0);
        cyc();
        #1;
        chk1("sh_valid_drop", o_valid, 1'b0);

        // ---- StoreByte at 0x41, zero-wait grant ----
        issue(1'b0, 1'b1, 3'd5, 32'h41, 32'h123456A5, 5'd0, 1'b0);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        #1;
        chk32("sb_wstrb", {28'd0, bus_wstrb}, 32'h2);
        chk32("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        chk32("sb_addr",  bus_addr,  32'h40);
        cyc();
        bus_gnt = 1'b0;
        #1;
        chk1("sb_valid", o_valid, 1'b1);
        cyc();

        // ---- misaligned LoadWord at 0x6 ----
        issue(1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 5'd4, 1'b1);
        chk1("mis_stall_accept", o_stall, 1'b1);
        cyc();
        drop_inputs();
        #1;
        chk1("mis_req",   bus_req, 1'b0);
        chk1("mis_valid", o_valid, 1'b1);
        chk1("mis_err",   o_err,   1'b1);
        chk1("mis_wback", o_wback, 1'b0);
        cyc();

        // ---- load flag with a store kind is illegal ----
        issue(1'b1, 1'b0, 3'd7, 32'h10, 32'd0, 5'd4, 1'b1);
        cyc();
        drop_inputs();
        #1;
        chk1("ill_req",   bus_req, 1'b0);
        chk1("ill_err",   o_err,   1'b1);
        chk1("ill_wback", o_wback, 1'b0);
        cyc();

        // ---- load and store flags both set ----
        issue(1'b1, 1'b1, 3'd2, 32'h10, 32'd0, 5'd4, 1'b1);
        cyc();
        drop_inputs();
        #1;
        chk1("both_req", bus_req, 1'b0);
        chk1("both_err", o_err,   1'b1);
        cyc();

        // ---- timeout, then a late rvalid in IDLE ----
        issue(1'b1, 1'b0, 3'd2, 32'h200, 32'd0, 5'd6, 1'b1);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        cyc();
        bus_gnt = 1'b0;
        for (int i = 0; i < TO - 1; i++) cyc();
        #1;
        chk1("to_valid_last_wait", o_valid, 1'b0);
        chk1("to_stall_last_wait", o_stall, 1'b1);
        cyc();
        #1;
        chk1("to_valid", o_valid, 1'b1);
        chk1("to_err",   o_err,   1'b1);
        chk1("to_wback", o_wback, 1'b0);
        cyc();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55555555;
        #1;
        chk1("to_late_stall", o_stall, 1'b0);
        cyc();
        bus_rvalid = 1'b0;
        #1;
        chk1("to_late_valid", o_valid, 1'b0);

        // ---- rvalid on the expiry cycle: data wins ----
        issue(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 5'd8, 1'b1);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        cyc();
        bus_gnt = 1'b0;
        for (int i = 0; i < TO - 1; i++) cyc();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFEF00D;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        chk1 ("exp_valid", o_valid, 1'b1);
        chk1 ("exp_err",   o_err,   1'b0);
        chk32("exp_data",  o_data,  32'hCAFEF00D);
        chk1 ("exp_wback", o_wback, 1'b1);
        cyc();

        // ---- reset during REQ drops bus_req at once ----
        issue(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 5'd2, 1'b1);
        cyc();
        drop_inputs();
        #1;
        chk1("rreq_req_before", bus_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rreq_req",   bus_req, 1'b0);
        chk1("rreq_stall", o_stall, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---- reset during WAIT, stale rvalid, then pass-through ----
        issue(1'b1, 1'b0, 3'd2, 32'h500, 32'd0, 5'd2, 1'b1);
        cyc();
        drop_inputs();
        bus_gnt = 1'b1;
        cyc();
        bus_gnt = 1'b0;
        #1;
        chk1("rwait_stall_before", o_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rwait_stall", o_stall, 1'b0);
        chk1("rwait_req",   bus_req, 1'b0);
        chk1("rwait_valid", o_valid, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h77777777;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        chk1("rwait_stale_valid", o_valid, 1'b0);
        chk1("rwait_stale_stall", o_stall, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'hABCD, 32'd0, 5'd9, 1'b1);
        cyc();
        drop_inputs();
        #1;
        chk1 ("post_pt_valid", o_valid, 1'b1);
        chk32("post_pt_data",  o_data,  32'hABCD);
        chk32("post_pt_wreg",  {27'd0, o_wreg}, 32'd9);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
